// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage constants and the fetch FSM state encoding.
package pc_fetch_unit_pkg;

    localparam int unsigned DefAddrW   = 11;
    localparam int unsigned DefResetPc = 0;
    localparam int unsigned DefCntW    = 16;

    typedef enum logic [1:0] {
        StPrime = 2'd0,
        StRun   = 2'd1,
        StRedir = 2'd2,
        StHalt  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control/status bundle between branch stage, hazard unit, instruction ROM and IF/ID.
interface pc_fetch_unit_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned CNT_W  = 16
);
    logic              stall;
    logic              salto_tomado;
    logic [ADDR_W-1:0] pc_salto;
    logic              halt_i;
    logic [ADDR_W-1:0] imem_addr;
    logic [ADDR_W-1:0] pc_plus1;
    logic              if_valid;
    logic              flush_ifid;
    logic              halted;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        output stall, salto_tomado, pc_salto, halt_i,
        input  imem_addr, pc_plus1, if_valid, flush_ifid, halted, fetch_count
    );

    modport slave (
        input  stall, salto_tomado, pc_salto, halt_i,
        output imem_addr, pc_plus1, if_valid, flush_ifid, halted, fetch_count
    );
endinterface

// File: rtl/pc_fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; reused for performance counters.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter owner: next-PC priority selection, redirect bubble, stall and HALT.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DefAddrW,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefResetPc),
    parameter int unsigned       CNT_W    = DefCntW
) (
    input logic             clk,
    input logic             reset_n,
    pc_fetch_unit_if.slave  bus
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic              if_valid_q;
    logic              halted_q;
    logic              flush;
    logic              cnt_en;

    assign pc_inc = pc_q + ADDR_W'(1);

    // Redirect outranks halt and stall: both refer to wrong-path instructions.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush   = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            StPrime: begin
                pc_d    = pc_inc;
                state_d = StRun;
            end
            StRun: begin
                if (bus.salto_tomado) begin
                    pc_d    = bus.pc_salto;
                    flush   = 1'b1;
                    state_d = StRedir;
                end else if (bus.halt_i) begin
                    state_d = StHalt;
                end else if (!bus.stall) begin
                    pc_d   = pc_inc;
                    cnt_en = 1'b1;
                end
            end
            StRedir: begin
                if (bus.salto_tomado) begin
                    pc_d  = bus.pc_salto;
                    flush = 1'b1;
                end else begin
                    if (!bus.stall) begin
                        pc_d = pc_inc;
                    end
                    state_d = StRun;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StPrime;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= (state_d == StRun);
            halted_q   <= (state_d == StHalt);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_fetch_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (cnt_en),
        .clr     (1'b0),
        .count   (bus.fetch_count)
    );

    assign bus.imem_addr  = pc_q;
    assign bus.pc_plus1   = pc_inc;
    assign bus.if_valid   = if_valid_q;
    assign bus.flush_ifid = flush;
    assign bus.halted     = halted_q;

endmodule
